frame_builder: RTL and testbench



---
 rtl/parser_pkg.sv | 31 +++
 rtl/frame_builder_if.sv | 26 ++
 rtl/frame_builder_tail_scan.sv | 19 +
 rtl/frame_builder.sv | 132 +++++++++++++
 tb/tb_frame_builder.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/parser_pkg.sv
// Shared framing constants, payload layout and builder state encoding for the
// byte-stream record parser slice.
package parser_pkg;

  localparam int DATE_LEN    = 8;
  localparam int PRICE_LEN   = 2;
  localparam int NUM_LEN     = 2;
  localparam int PAYLOAD_LEN = 12;
  localparam int PAT_LEN     = 4;

  // Index 0 of each pattern is the first byte on the wire.
  localparam logic [PAT_LEN-1:0][7:0] HEAD_PAT = {8'h11, 8'h11, 8'h11, 8'h11};
  localparam logic [PAT_LEN-1:0][7:0] TAIL_PAT = {8'h11, 8'h00, 8'h11, 8'h00};

  localparam logic [3:0] HEAD_LAST    = 4'd3;
  localparam logic [3:0] PAYLOAD_LAST = 4'd11;
  localparam logic [3:0] TAIL_LAST    = 4'd3;

  typedef logic [PAYLOAD_LEN-1:0][7:0] payload_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEAD    = 3'd1,
    BUBBLE  = 3'd2,
    PAYLOAD = 3'd3,
    TAIL    = 3'd4,
    GAP     = 3'd5,
    REJ     = 3'd6
  } fb_state_t;

endpackage

// File: rtl/frame_builder_if.sv
// Record-in / byte-stream-out bundle of the frame builder. Handshake: a record
// transfers in every cycle where in_valid && in_ready; data is qualified by data_valid.
interface frame_builder_if;
  import parser_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  logic [DATE_LEN-1:0][7:0]   in_date;
  logic [PRICE_LEN-1:0][7:0]  in_price;
  logic [NUM_LEN-1:0][7:0]    in_num;
  logic [7:0]                 data;
  logic                       data_valid;
  logic                       err;
  logic                       busy;

  modport master (
    output in_valid, in_date, in_price, in_num,
    input  in_ready, data, data_valid, err, busy
  );

  modport slave (
    input  in_valid, in_date, in_price, in_num,
    output in_ready, data, data_valid, err, busy
  );

endinterface

// File: rtl/frame_builder_tail_scan.sv
// Combinational check: flags a payload containing the TAIL pattern in any
// 4-byte window lying wholly inside the 12 payload bytes.
module frame_tail_scan
  import parser_pkg::*;
(
  input  payload_t payload,
  output logic     hit
);

  always_comb begin
    hit = 1'b0;
    for (int w = 0; w <= PAYLOAD_LEN - PAT_LEN; w++) begin
      if (payload[w]   == TAIL_PAT[0] && payload[w+1] == TAIL_PAT[1] &&
          payload[w+2] == TAIL_PAT[2] && payload[w+3] == TAIL_PAT[3])
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/frame_builder.sv
// Serialises one record into HEAD / bubble / 12-byte payload / TAIL / gap.
// Optional macro FRAME_BUILDER_CNT_EN adds saturating frames_sent/frames_dropped.
module frame_builder
  import parser_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  frame_builder_if.slave  bus,
  output fb_state_t       dbg_state
`ifdef FRAME_BUILDER_CNT_EN
  ,
  output logic [15:0]     frames_sent,
  output logic [15:0]     frames_dropped
`endif
);

  localparam int         GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [3:0] GAP_LAST   = GAP_LAST_I[3:0];

  fb_state_t  state_q, state_d;
  logic [3:0] idx_q, idx_d;
  payload_t   pay_in, pay_q;
  logic       hit, accept;
  logic [7:0] data_q, byte_d;
  logic       dv_q, err_q, busy_q, ready_q;

  assign pay_in = {bus.in_num, bus.in_price, bus.in_date};

  frame_tail_scan u_scan (
    .payload (pay_in),
    .hit     (hit)
  );

  assign accept = (state_q == IDLE) && ready_q && bus.in_valid;

  // The index restarts at every state change; each state ends at its last index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q + 4'd1;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (accept) state_d = hit ? REJ : HEAD;
      end
      HEAD: if (idx_q == HEAD_LAST) begin
        state_d = BUBBLE;
        idx_d   = '0;
      end
      BUBBLE: begin
        state_d = PAYLOAD;
        idx_d   = '0;
      end
      PAYLOAD: if (idx_q == PAYLOAD_LAST) begin
        state_d = TAIL;
        idx_d   = '0;
      end
      TAIL: if (idx_q == TAIL_LAST) begin
        state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
        idx_d   = '0;
      end
      GAP: if (idx_q == GAP_LAST) begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so they line up with it after the edge.
  always_comb begin
    byte_d = data_q;
    case (state_d)
      HEAD:    byte_d = HEAD_PAT[idx_d[1:0]];
      PAYLOAD: byte_d = pay_q[idx_d];
      TAIL:    byte_d = TAIL_PAT[idx_d[1:0]];
      default: byte_d = data_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= byte_d;
      dv_q    <= (state_d == HEAD) || (state_d == PAYLOAD) || (state_d == TAIL);
      err_q   <= accept && hit;
      busy_q  <= (state_d != IDLE);
      ready_q <= (state_d == IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) pay_q <= pay_in;
  end

  assign bus.data       = data_q;
  assign bus.data_valid = dv_q;
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;
  assign bus.in_ready   = ready_q;
  assign dbg_state      = state_q;

`ifdef FRAME_BUILDER_CNT_EN
  logic last_tail;
  assign last_tail = (state_d == TAIL) && (idx_d == TAIL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      frames_sent    <= '0;
      frames_dropped <= '0;
    end else begin
      if (last_tail && frames_sent != 16'hFFFF) frames_sent <= frames_sent + 16'd1;
      if (accept && hit && frames_dropped != 16'hFFFF)
        frames_dropped <= frames_dropped + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_builder.sv
// Bench for frame_builder: randomized and directed records against a
// cycle-stamped expected-byte queue built from the frame layout rules.
module tb_frame_builder;
  import parser_pkg::*;

  localparam int GAP = 2;
  localparam int W   = 40;  // {cycle[31:0], byte[7:0]}

  typedef logic [DATE_LEN-1:0][7:0] date_t;
  typedef logic [1:0][7:0]          pn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  frame_builder_if bus ();
  fb_state_t dbg_state;
`ifdef FRAME_BUILDER_CNT_EN
  logic [15:0] frames_sent, frames_dropped;
`endif

  frame_builder #(.GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef FRAME_BUILDER_CNT_EN
    ,
    .frames_sent    (frames_sent),
    .frames_dropped (frames_dropped)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           err_q[$];
  int           sent_q[$];
  int           checks = 0;
  int           errors = 0;
  int           ready_cycle = 0;
  int           busy_start = 1;
  int           busy_end = 0;
  int           rst_eff = -1;
  logic [7:0]   exp_hold = 8'h00;
  int           exp_sent = 0;
  int           exp_dropped = 0;
  bit           mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a frame is the byte list HEAD, payload, TAIL stamped with
  // the cycles at which the layout rules place them.
  task automatic model_accept(input int c);
    logic [7:0] b[PAYLOAD_LEN];
    logic [7:0] tl[4];
    bit bad;
    bad = 1'b0;
    tl[0] = 8'h00; tl[1] = 8'h11; tl[2] = 8'h00; tl[3] = 8'h11;
    for (int i = 0; i < 8; i++) b[i] = bus.in_date[i];
    b[8]  = bus.in_price[0];
    b[9]  = bus.in_price[1];
    b[10] = bus.in_num[0];
    b[11] = bus.in_num[1];
    for (int w = 0; w <= 8; w++)
      if (b[w] == tl[0] && b[w+1] == tl[1] && b[w+2] == tl[2] && b[w+3] == tl[3]) bad = 1'b1;
    busy_start = c + 1;
    if (bad) begin
      err_q.push_back(c + 1);
      ready_cycle = c + 2;
      busy_end    = c + 1;
    end else begin
      for (int k = 0; k < 4; k++)  exp_q.push_back({32'(c + 1 + k), 8'h11});
      for (int k = 0; k < 12; k++) exp_q.push_back({32'(c + 6 + k), b[k]});
      for (int k = 0; k < 4; k++)  exp_q.push_back({32'(c + 18 + k), tl[k]});
      sent_q.push_back(c + 21);
      ready_cycle = c + 22 + GAP;
      busy_end    = c + 21 + GAP;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    int  c;
    bit  exp_dv, exp_err, exp_busy;
    forever begin
      @(negedge clk);
      c = cyc;
      if (c == rst_eff) begin
        exp_hold    = 8'h00;
        exp_sent    = 0;
        exp_dropped = 0;
      end
      if (mon_en) begin
        exp_dv = (exp_q.size() > 0) && (int'(exp_q[0][39:8]) == c);
        check("data_valid", 32'(bus.data_valid), 32'(exp_dv));
        if (exp_dv) begin
          exp_hold = exp_q[0][7:0];
          void'(exp_q.pop_front());
        end
        check("data", 32'(bus.data), 32'(exp_hold));

        exp_err = (err_q.size() > 0) && (err_q[0] == c);
        if (exp_err) begin
          void'(err_q.pop_front());
          if (exp_dropped < 65535) exp_dropped++;
        end
        check("err", 32'(bus.err), 32'(exp_err));
        check("in_ready", 32'(bus.in_ready), 32'(c >= ready_cycle));
        exp_busy = (c >= busy_start) && (c <= busy_end);
        check("busy", 32'(bus.busy), 32'(exp_busy));
        check("state_idle", 32'(dbg_state == IDLE), 32'(!exp_busy));

        if (sent_q.size() > 0 && sent_q[0] == c) begin
          void'(sent_q.pop_front());
          if (exp_sent < 65535) exp_sent++;
        end
`ifdef FRAME_BUILDER_CNT_EN
        check("frames_sent", 32'(frames_sent), 32'(exp_sent));
        check("frames_dropped", 32'(frames_dropped), 32'(exp_dropped));
`endif
      end

      if (rst) begin
        exp_q.delete();
        err_q.delete();
        sent_q.delete();
        ready_cycle = c + 2;
        busy_end    = c;
        rst_eff     = c + 1;
      end else if (bus.in_valid && c >= ready_cycle) begin
        model_accept(c);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input date_t d, input pn_t p, input pn_t n);
    bit ok;
    int budget;
    ok = 1'b0;
    budget = 0;
    bus.in_valid = 1'b1;
    bus.in_date  = d;
    bus.in_price = p;
    bus.in_num   = n;
    while (!ok && budget < 100) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    check("accept_in_time", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_random();
    logic [7:0] b[PAYLOAD_LEN];
    date_t d;
    pn_t   p, n;
    int    w, kind;
    for (int i = 0; i < PAYLOAD_LEN; i++) b[i] = 8'($urandom_range(0, 255));
    kind = $urandom_range(0, 7);
    w    = $urandom_range(0, 8);
    if (kind <= 1) begin
      b[w] = 8'h00; b[w+1] = 8'h11; b[w+2] = 8'h00; b[w+3] = 8'h11;
    end else if (kind == 2) begin
      b[w] = 8'h00; b[w+1] = 8'h11; b[w+2] = 8'h00;
    end
    for (int i = 0; i < 8; i++) d[i] = b[i];
    p[0] = b[8];  p[1] = b[9];
    n[0] = b[10]; n[1] = b[11];
    send(d, p, n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    date_t d1, d2;
    pn_t   p1, n1, p2, n2;
    int    budget;

    bus.in_valid = 1'b0;
    bus.in_date  = '0;
    bus.in_price = '0;
    bus.in_num   = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // "2023/03/" with price 41 30 and num 30 32
    d1 = {8'h2f, 8'h33, 8'h30, 8'h2f, 8'h33, 8'h32, 8'h30, 8'h32};
    p1 = {8'h30, 8'h41};
    n1 = {8'h32, 8'h30};
    send(d1, p1, n1);
    idle(30);

    // Two distinct records with in_valid held high between them
    d2 = {8'h31, 8'h30, 8'h2f, 8'h34, 8'h30, 8'h2f, 8'h34, 8'h32};
    p2 = {8'h35, 8'h39};
    n2 = {8'h37, 8'h31};
    send(d1, p1, n1);
    send(d2, p2, n2);
    idle(30);

    // TAIL inside price/num: rejected
    send(d1, {8'h11, 8'h00}, {8'h11, 8'h00});
    idle(4);

    // Reset while payload byte 5 is on the wire, then a full frame
    send(d2, p2, n2);
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(d1, p1, n1);
    idle(30);

    // Input churn and in_valid pulses while a frame is in flight
    send(d2, p2, n2);
    for (int i = 0; i < 15; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      for (int j = 0; j < 8; j++) bus.in_date[j] = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end
    idle(15);

    // Random records, some back-to-back, some with gaps
    for (int r = 0; r < 40; r++) begin
      send_random();
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 5));
    end
    bus.in_valid = 1'b0;

    budget = 0;
    while ((exp_q.size() > 0 || err_q.size() > 0) && budget < 200) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("drain_bytes", 32'(exp_q.size()), 32'd0);
    check("drain_errs", 32'(err_q.size()), 32'd0);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
